// File: rtl/morra_pkg.sv
// Shared types and the reference round rule for the MorraCinese match driver.
package morra_pkg;

   typedef enum logic [1:0] {
      MV_NONE     = 2'b00,
      MV_ROCK     = 2'b01,
      MV_PAPER    = 2'b10,
      MV_SCISSORS = 2'b11
   } move_t;

   typedef enum logic [1:0] {
      RND_INVALID = 2'b00,
      RND_P1      = 2'b01,
      RND_P2      = 2'b10,
      RND_DRAW    = 2'b11
   } round_t;

   typedef enum logic [1:0] {
      GM_ONGOING = 2'b00,
      GM_P1      = 2'b01,
      GM_P2      = 2'b10,
      GM_DRAW    = 2'b11
   } game_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STRT,
      ST_PLAY,
      ST_CHECK,
      ST_DONE
   } drv_state_t;

   localparam int unsigned DEF_DEPTH      = 4;
   localparam int unsigned DEF_IDX_W      = 5;
   localparam int unsigned DEF_MAX_ROUNDS = 31;

   // rock > scissors > paper > rock; any empty move voids the round
   function automatic round_t exp_round(input move_t p1, input move_t p2);
      if (p1 == MV_NONE || p2 == MV_NONE) return RND_INVALID;
      if (p1 == p2) return RND_DRAW;
      if ((p1 == MV_ROCK     && p2 == MV_SCISSORS) ||
          (p1 == MV_SCISSORS && p2 == MV_PAPER)    ||
          (p1 == MV_PAPER    && p2 == MV_ROCK))
         return RND_P1;
      return RND_P2;
   endfunction

endpackage

// File: rtl/morra_move_fifo.sv
// Move-pair FIFO (DEPTH entries x WIDTH bits), extra pointer bit distinguishes full from empty.
module morra_move_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic             wr_fire, rd_fire;

   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_fire   = rd_en_i && !empty_o;
   // a push into a full FIFO is legal when the same edge pops
   assign wr_fire   = wr_en_i && (!full_o || rd_fire);
   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (wr_fire) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
            wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
         end
         if (rd_fire) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/morra_match_driver.sv
// Host-side driver for the MorraCinese core: issues one move pair per round and reports results.
// Optional reference-model scoreboard enabled by defining MORRA_SCOREBOARD_EN.
module morra_match_driver
   import morra_pkg::*;
#(
   parameter int unsigned DEPTH      = DEF_DEPTH,
   parameter int unsigned IDX_W      = DEF_IDX_W,
   parameter int unsigned MAX_ROUNDS = DEF_MAX_ROUNDS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [3:0]       cfg_min_rounds,
   input  logic             mv_valid,
   output logic             mv_ready,
   input  logic [1:0]       mv_p1,
   input  logic [1:0]       mv_p2,
   output logic [1:0]       P1,
   output logic [1:0]       P2,
   output logic             START,
   input  logic [1:0]       ROUND,
   input  logic [1:0]       GAME,
   output logic             res_valid,
   output logic [1:0]       res_round,
   output logic [IDX_W-1:0] res_idx,
   output logic             busy,
   output logic             done,
   output logic [1:0]       game_result,
   output logic             timeout,
   output logic             err_mismatch
);

   localparam logic [IDX_W-1:0] MAX_CNT = IDX_W'(MAX_ROUNDS);

   drv_state_t       state_q, state_d;
   logic [1:0]       p1_q, p1_d, p2_q, p2_d;
   logic             start_q, start_d;
   logic             res_valid_q, res_valid_d;
   logic [1:0]       res_round_q, res_round_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic [1:0]       game_q, game_d;
   logic             timeout_q, timeout_d;

   logic             fifo_wr, fifo_rd, fifo_full, fifo_empty;
   logic [3:0]       fifo_rdata;
   logic             cfg_acc;

   morra_move_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (4)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (fifo_wr),
      .wr_data_i ({mv_p1, mv_p2}),
      .rd_en_i   (fifo_rd),
      .rd_data_o (fifo_rdata),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign busy      = !cfg_ready;
   assign mv_ready  = !fifo_full && (state_q != ST_DONE);
   assign fifo_wr   = mv_valid && mv_ready;
   assign cfg_acc   = cfg_valid && cfg_ready;

   always_comb begin
      state_d     = state_q;
      p1_d        = MV_NONE;
      p2_d        = MV_NONE;
      start_d     = 1'b0;
      res_valid_d = 1'b0;
      res_round_d = res_round_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;
      game_d      = game_q;
      timeout_d   = timeout_q;
      fifo_rd     = 1'b0;
      case (state_q)
         ST_STRT: state_d = ST_PLAY;
         ST_PLAY: begin
            if (!fifo_empty) begin
               fifo_rd = 1'b1;
               p1_d    = fifo_rdata[3:2];
               p2_d    = fifo_rdata[1:0];
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            res_valid_d = 1'b1;
            res_round_d = ROUND;
            if (ROUND != RND_INVALID && cnt_q != MAX_CNT) cnt_d = cnt_q + 1'b1;
            if (cnt_d == MAX_CNT) timeout_d = 1'b1;
            if (GAME != GM_ONGOING || cnt_d == MAX_CNT) begin
               game_d  = GAME;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               state_d = ST_PLAY;
            end
         end
         ST_DONE: fifo_rd = !fifo_empty;
         default: ;
      endcase
      // cfg_acc is only possible from IDLE/DONE, so this overrides those branches alone
      if (cfg_acc) begin
         state_d      = ST_STRT;
         start_d      = 1'b1;
         {p1_d, p2_d} = cfg_min_rounds;
         cnt_d        = '0;
         game_d       = GM_ONGOING;
         timeout_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         p1_q        <= '0;
         p2_q        <= '0;
         start_q     <= 1'b0;
         res_valid_q <= 1'b0;
         res_round_q <= '0;
         cnt_q       <= '0;
         done_q      <= 1'b0;
         game_q      <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         p1_q        <= p1_d;
         p2_q        <= p2_d;
         start_q     <= start_d;
         res_valid_q <= res_valid_d;
         res_round_q <= res_round_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         game_q      <= game_d;
         timeout_q   <= timeout_d;
      end
   end

`ifdef MORRA_SCOREBOARD_EN
   logic err_q, err_d;

   // p1_q/p2_q still hold the pair the core is answering during CHECK
   always_comb begin
      err_d = err_q;
      if (cfg_acc)
         err_d = 1'b0;
      else if (state_q == ST_CHECK && round_t'(ROUND) != exp_round(move_t'(p1_q), move_t'(p2_q)))
         err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign err_mismatch = err_q;
`else
   assign err_mismatch = 1'b0;
`endif

   assign P1          = p1_q;
   assign P2          = p2_q;
   assign START       = start_q;
   assign res_valid   = res_valid_q;
   assign res_round   = res_round_q;
   assign res_idx     = cnt_q;
   assign done        = done_q;
   assign game_result = game_q;
   assign timeout     = timeout_q;

endmodule
